// File: rtl/quad_enc_gen.sv
// ---------------------------------------------------------------------------
// quad_enc_gen
// Quadrature encoder emulator. Accepts a move command (direction, number of
// quadrature edges, sclk cycles per edge) and steps an internal position
// counter, emitting the matching A/B channel levels and an optional index.
//
// Parameters
//   SYSCLK_FREQ     sclk frequency in Hz (informational)
//   COUNTS_PER_REV  quadrature states per revolution (multiple of 4)
//   POS_W           position width
//
// Ports
//   sclk        in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   cmd_valid   in   command offered
//   cmd_ready   out  block idle and able to accept a command
//   cmd_dir     in   1 = forward (A leads B), 0 = reverse
//   cmd_steps   in   number of quadrature edges to emit
//   cmd_period  in   sclk cycles per edge (0 behaves as 1)
//   abort       in   stop the active command, no done pulse
//   enc_a       out  channel A
//   enc_b       out  channel B
//   enc_i       out  index, high while position == 0
//   position    out  current quadrature state count
//   busy        out  command in progress
//   done        out  one-cycle completion pulse
//
// Build option
//   QENC_INDEX_EN  when defined, enc_i is a registered position==0 flag;
//                  otherwise enc_i is tied low and no compare is built.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready high
// RUN   | emitting edges, one every period cycles until steps exhausted
// ---------------------------------------------------------------------------
module quad_enc_gen #(
  parameter int SYSCLK_FREQ    = 100_000_000,
  parameter int COUNTS_PER_REV = 8192,
  parameter int POS_W          = $clog2(COUNTS_PER_REV)
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [15:0]      cmd_steps,
  input  logic [15:0]      cmd_period,
  input  logic             abort,
  output logic             enc_a,
  output logic             enc_b,
  output logic             enc_i,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             done
);

  if ((COUNTS_PER_REV < 4) || ((COUNTS_PER_REV % 4) != 0)) begin : g_bad_cpr
    $error("quad_enc_gen: COUNTS_PER_REV must be a positive multiple of 4");
  end
  if (SYSCLK_FREQ <= 0) begin : g_bad_clk
    $error("quad_enc_gen: SYSCLK_FREQ must be positive");
  end

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(COUNTS_PER_REV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic              dir_q, dir_d;
  logic [15:0]       period_q, period_d;
  logic [15:0]       timer_q, timer_d;
  logic [15:0]       remaining_q, remaining_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              done_pend_q, done_pend_d;
  logic              done_q;
  logic              enc_a_q, enc_b_q;

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      period_q    <= 16'd1;
      timer_q     <= '0;
      remaining_q <= '0;
      pos_q       <= '0;
      done_pend_q <= 1'b0;
      done_q      <= 1'b0;
      enc_a_q     <= 1'b0;
      enc_b_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      period_q    <= period_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
      pos_q       <= pos_d;
      // completion is flagged on the last-step edge and shown one cycle later
      done_pend_q <= done_pend_d;
      done_q      <= done_pend_q;
      // A/B decoded from the next position so they change with position
      enc_a_q     <= pos_d[1] ^ pos_d[0];
      enc_b_q     <= pos_d[1];
    end
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    period_d    = period_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    pos_d       = pos_q;
    done_pend_d = 1'b0;
    case (state_q)
      IDLE: begin
        // abort is ignored here, so a command offered with abort still lands
        if (cmd_valid) begin
          dir_d       = cmd_dir;
          period_d    = (cmd_period == 16'd0) ? 16'd1 : cmd_period;
          timer_d     = '0;
          remaining_d = cmd_steps;
          if (cmd_steps == 16'd0) begin
            done_pend_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          // abort beats a coincident step edge: position holds
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == period_q - 16'd1) begin
          timer_d     = '0;
          remaining_d = remaining_q - 16'd1;
          if (dir_q) begin
            pos_d = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
          end else begin
            pos_d = (pos_q == '0) ? POS_MAX : pos_q - 1'b1;
          end
          if (remaining_q == 16'd1) begin
            state_d     = IDLE;
            done_pend_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
    endcase
  end

`ifdef QENC_INDEX_EN
  logic enc_i_q;

  always_ff @(posedge sclk) begin
    if (rst) begin
      enc_i_q <= 1'b1;
    end else begin
      enc_i_q <= (pos_d == '0);
    end
  end

  assign enc_i = enc_i_q;
`else
  assign enc_i = 1'b0;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign position  = pos_q;
  assign enc_a     = enc_a_q;
  assign enc_b     = enc_b_q;

endmodule

// File: tb/tb_quad_enc_gen.sv
module tb_quad_enc_gen;

  localparam int N = 8192;

  logic        sclk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [15:0] cmd_steps;
  logic [15:0] cmd_period;
  logic        abort;
  logic        enc_a;
  logic        enc_b;
  logic        enc_i;
  logic [12:0] position;
  logic        busy;
  logic        done;

  int tests     = 0;
  int fails     = 0;
  int model_pos = 0;
  int a_rises   = 0;

  always #5 sclk = ~sclk;

  quad_enc_gen dut (
    .sclk       (sclk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
    .abort      (abort),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .enc_i      (enc_i),
    .position   (position),
    .busy       (busy),
    .done       (done)
  );

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wrap(input int x);
    return ((x % N) + N) % N;
  endfunction

  // quadrature state -> {A,B}: 0->00, 1->10, 2->11, 3->01
  function automatic int ab_of(input int pos);
    case (pos % 4)
      0:       return 0;
      1:       return 2;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int idx_of(input int pos);
`ifdef QENC_INDEX_EN
    return (pos == 0) ? 1 : 0;
`else
    return 0 * pos;
`endif
  endfunction

  task automatic check_outputs(input string tag, input int pos, input bit bsy, input bit dn);
    check({tag, " pos"},   int'(position),      pos);
    check({tag, " ab"},    int'({enc_a, enc_b}), ab_of(pos));
    check({tag, " idx"},   int'(enc_i),         idx_of(pos));
    check({tag, " busy"},  int'(busy),          int'(bsy));
    check({tag, " ready"}, int'(cmd_ready),     int'(!bsy));
    check({tag, " done"},  int'(done),          int'(dn));
  endtask

  // Issue one command and check every cycle from the accept edge T onward.
  // ab   : >0 means abort is sampled at edge T+ab
  // poke : >=0 means cmd_valid is sampled (and must be ignored) at T+poke+1
  // ab_acc : abort held high on the accepting edge (must be ignored)
  task automatic run_cmd(input bit dir, input int steps, input int period,
                         input int ab, input int poke, input bit ab_acc,
                         input string tag);
    int  p, run_len, n_eff, busy_len, last_c, n, pos, start;
    bit  prev_a;
    p        = (period == 0) ? 1 : period;
    run_len  = steps * p;
    n_eff    = steps;
    busy_len = run_len;
    if (ab > 0) begin
      n_eff = (ab - 1) / p;
      if (n_eff > steps) n_eff = steps;
      busy_len = ab;
    end
    last_c = (ab > 0) ? ab : run_len + 1;
    start  = model_pos;
    check({tag, " pre_ready"}, int'(cmd_ready), 1);
    cmd_valid  = 1'b1;
    cmd_dir    = dir;
    cmd_steps  = 16'(steps);
    cmd_period = 16'(period);
    abort      = ab_acc;
    prev_a     = enc_a;
    tick();
    for (int c = 0; c <= last_c; c++) begin
      if (c > 0) tick();
      cmd_valid  = 1'b0;
      abort      = 1'b0;
      cmd_dir    = 1'($urandom);
      cmd_steps  = 16'($urandom_range(1, 40));
      cmd_period = 16'($urandom_range(0, 9));
      n = c / p;
      if (n > n_eff) n = n_eff;
      pos = wrap(start + (dir ? n : -n));
      if (enc_a && !prev_a) a_rises++;
      prev_a = enc_a;
      check_outputs(tag, pos, c < busy_len, (ab == 0) && (c == run_len + 1));
      if (ab > 0 && c + 1 == ab) abort = 1'b1;
      if (c == poke) cmd_valid = 1'b1;
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    model_pos = wrap(start + (dir ? n_eff : -n_eff));
  endtask

  initial begin
    int st, pr, pr1, ab, pk;
    bit dr;

    // reset with a command offered: must not be accepted
    rst        = 1'b1;
    cmd_valid  = 1'b1;
    cmd_dir    = 1'b1;
    cmd_steps  = 16'd5;
    cmd_period = 16'd1;
    abort      = 1'b0;
    tick();
    tick();
    check_outputs("reset", 0, 1'b0, 1'b0);
    rst       = 1'b0;
    cmd_valid = 1'b0;
    tick();
    check_outputs("post_reset", 0, 1'b0, 1'b0);

    run_cmd(1'b0, 2, 0, 0, -1, 1'b0, "rev_wrap");
    check("rev_wrap_end", int'(position), 8190);
    run_cmd(1'b1, 2, 1, 0, -1, 1'b0, "fwd_back");
    run_cmd(1'b1, 4, 10, 0, -1, 1'b0, "fwd4");
    check("fwd4_end", int'(position), 4);
    run_cmd(1'b0, 4, 3, 0, -1, 1'b0, "rev4");

    a_rises = 0;
    run_cmd(1'b1, N, 1, 0, -1, 1'b0, "full_rev");
    check("full_rev_a_rises", a_rises, N / 4);
    check("full_rev_end", int'(position), 0);

    run_cmd(1'b1, 10, 5, 17, -1, 1'b0, "abort");
    check("abort_end", int'(position), 3);
    run_cmd(1'b1, 0, 7, 0, -1, 1'b0, "zero_steps");
    run_cmd(1'b0, 6, 4, 0, 5, 1'b0, "busy_poke");
    run_cmd(1'b1, 5, 2, 0, -1, 1'b1, "abort_idle");
    run_cmd(1'b0, 5, 3, 9, -1, 1'b0, "abort_edge");

    for (int i = 0; i < 12; i++) begin
      dr  = 1'($urandom);
      st  = int'($urandom_range(0, 12));
      pr  = int'($urandom_range(0, 6));
      pr1 = (pr == 0) ? 1 : pr;
      ab  = 0;
      pk  = -1;
      if (st > 0) begin
        if ($urandom_range(0, 2) == 0) ab = int'($urandom_range(1, st * pr1));
        else if ($urandom_range(0, 1) == 0) pk = int'($urandom_range(0, st * pr1 - 1));
      end
      run_cmd(dr, st, pr, ab, pk, 1'b0, "random");
    end

    // reset in the middle of a command
    cmd_valid  = 1'b1;
    cmd_dir    = 1'b1;
    cmd_steps  = 16'd20;
    cmd_period = 16'd2;
    tick();
    cmd_valid = 1'b0;
    repeat (7) tick();
    check("mid_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    model_pos = 0;
    check_outputs("mid_rst", 0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    tick();
    check_outputs("after_rst", 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/quad_enc_gen.md
QUAD_ENC_GEN -- requirements
Module: quad_enc_gen

Interface
REQ-001 The block SHALL have parameter SYSCLK_FREQ, default 100_000_000, meaning the sclk frequency in Hz (informational only).
REQ-002 The block SHALL have parameter COUNTS_PER_REV, default 8192, meaning quadrature states per revolution; it shall be a multiple of 4.
REQ-003 The block SHALL have parameter POS_W, default $clog2(COUNTS_PER_REV), meaning the position width.
REQ-004 The block SHALL have a single clock and a synchronous, active-high reset:
- sclk  input  1  system clock; all logic is clocked on its rising edge.
- rst  input  1  synchronous active-high reset.
REQ-005 The block SHALL have the following command ports:
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  block accepts a command.
- cmd_dir  input  1  1 = forward (A leads B), 0 = reverse.
- cmd_steps  input  16  number of quadrature edges to emit.
- cmd_period  input  16  sclk cycles per edge; 0 is treated as 1.
- abort  input  1  stop the active command.
REQ-006 The block SHALL have the following output ports:
- enc_a  output  1  emulated channel A.
- enc_b  output  1  emulated channel B.
- enc_i  output  1  emulated index.
- position  output  POS_W  current quadrature state count.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion pulse.

Function
REQ-007 The block SHALL implement two states, IDLE and RUN; cmd_ready SHALL equal (state == IDLE), and busy SHALL equal (state == RUN).
REQ-008 A command SHALL be accepted on a cycle where cmd_valid and cmd_ready are both 1; acceptance latches dir, steps and period (period 0 is latched as 1) and zeroes the period timer.
REQ-009 Acceptance with cmd_steps = 0 SHALL stay in IDLE and pulse done high for 1 cycle, in the cycle after acceptance; otherwise the block SHALL enter RUN.
REQ-010 In RUN, the timer SHALL count 0..period-1; at the cycle where the timer equals period-1, the block SHALL:
- update position (+1 if forward, -1 if reverse);
- decrement the remaining-step counter;
- restart the timer at 0.
REQ-011 For a command accepted at edge T, the k-th position change SHALL be visible at edge T+k*period.
REQ-012 Position SHALL wrap: forward from COUNTS_PER_REV-1 goes to 0; reverse from 0 goes to COUNTS_PER_REV-1. The wrap compares against COUNTS_PER_REV and does not rely on power-of-2 overflow.
REQ-013 {enc_a,enc_b} SHALL be registered and decoded from position[1:0]: 0→00, 1→10, 2→11, 3→01.
REQ-014 When the last step is applied, the block SHALL return to IDLE on the same edge and pulse done in the following cycle; cmd_ready is 1 in that cycle.
REQ-015 abort in RUN SHALL return the block to IDLE on the next edge:
- no further edges are emitted and position holds;
- done is not pulsed;
- if abort coincides with a step edge, abort wins and the edge is suppressed.
REQ-016 abort in IDLE SHALL be ignored; abort asserted with cmd_valid in IDLE SHALL still accept the command.
REQ-017 cmd_valid while busy SHALL be ignored and SHALL not be queued.
REQ-018 All outputs SHALL be driven from registers, with no combinational path from inputs to outputs.

Reset
REQ-019 rst SHALL force the following values at the next sclk edge, regardless of state (including mid-command):
- state = IDLE, position = 0, timer = 0, remaining = 0;
- enc_a = 0, enc_b = 0;
- enc_i per REQ-021;
- busy = 0, done = 0, cmd_ready = 1.
REQ-020 A command presented in the cycle rst is high SHALL NOT be accepted.

Configuration
REQ-021 With macro QENC_INDEX_EN defined, enc_i SHALL be a registered 1 while position == 0 and 0 otherwise (reset value 1).
REQ-022 Without QENC_INDEX_EN, enc_i SHALL be tied constant 0 and no index compare logic SHALL be synthesized.

Verification
REQ-023 Reset: assert rst 2 cycles → A=0, B=0, I=1 (macro on), position=0, cmd_ready=1, busy=0, done=0.
REQ-024 Forward 4 steps: dir=1, steps=4, period=10, accepted at T → position 1,2,3,4 at T+10/20/30/40; AB=10,11,01,00; done high only at T+41.
REQ-025 Reverse wrap: from position 0, dir=0, steps=2, period=0 → position 8191 at T+1 and 8190 at T+2; AB=01 then 11; I falls at T+1; done at T+3.
REQ-026 Full revolution: dir=1, steps=8192, period=1 → I high exactly at T and T+8192; position ends at 0; A shows 2048 rising edges.
REQ-027 Abort: steps=10, period=5, abort held 1 cycle at T+17 → position=3 held; no done pulse; cmd_ready=1 at T+18; a new command accepted at T+18.
REQ-028 Zero steps / busy: steps=0 → done at T+1 with no A/B change; cmd_valid pulsed during RUN → ignored, final position unchanged.
